// File: rtl/ysyx_22050854_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one 32-bit word at a time and holds it for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN turns a misaligned redirect target into a sticky fault plus halt.
module ysyx_22050854_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        fetch_misalign,
`endif
    output logic [2:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Valids come straight from the state register; ready is never needed to raise valid,
    // and payload (address / instruction / pc) is held constant while valid waits for ready.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic [31:0] instr_q;
    logic [63:0] instr_pc_q;
    logic        load_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_q;
    logic        misalign_set;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_instr = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_set = 1'b0;
`endif
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_req_ready) state_next = WAIT;
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    load_instr = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // halt and redirect only matter on the cycle decode takes the instruction
                if (instr_ready) begin
                    if (halt) begin
                        state_next = HALT;
                    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (redirect_pc[1:0] != 2'b00) begin
                            misalign_set = 1'b1;
                            state_next   = HALT;
                        end else begin
                            pc_next    = redirect_pc;
                            state_next = REQ;
                        end
`else
                        pc_next    = redirect_pc & ~64'h3;
                        state_next = REQ;
`endif
                    end else begin
                        pc_next    = pc + 64'd4;
                        state_next = REQ;
                    end
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_instr) begin
                instr_q    <= imem_resp_data;
                instr_pc_q <= pc;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misalign_set) misalign_q <= 1'b1;
`endif
        end
    end

    assign imem_req_valid = (state == REQ);
    assign instr_valid    = (state == HOLD);
    assign imem_req_addr  = pc;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign fsm_state      = state;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_22050854_fetch_unit.sv
// Bench for ysyx_22050854_fetch_unit: cycle vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level model of the fetch stream.
module tb_ysyx_22050854_fetch_unit;

    localparam logic [63:0] A = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt = 1'b0;
    logic [2:0]  fsm_state;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ysyx_22050854_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .fsm_state      (fsm_state)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        halt            = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the DUT in IDLE (cycle 0) at a negedge with rst low.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // From REQ: zero-wait accept and response, ends in HOLD.
    task automatic fetch_to_hold(input logic [31:0] data);
        clear_inputs();
        imem_req_ready = 1'b1;
        step();
        clear_inputs();
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        clear_inputs();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        xv;
        logic [63:0] xp;
        logic        h;
        logic        e_qv;
        logic [63:0] e_qa;
        logic        e_iv;
        logic [31:0] e_id;
        logic [63:0] e_ip;
    } vec_t;

    function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                                input logic ir, input logic xv, input logic [63:0] xp,
                                input logic h, input logic e_qv, input logic [63:0] e_qa,
                                input logic e_iv, input logic [31:0] e_id, input logic [63:0] e_ip);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.xv = xv; v.xp = xp; v.h = h;
        v.e_qv = e_qv; v.e_qa = e_qa; v.e_iv = e_iv; v.e_id = e_id; v.e_ip = e_ip;
        return v;
    endfunction

    vec_t tbl[20];

    // ---------------- scoreboard for random phase ----------------
    logic [31:0] exp_q[$];
    logic [63:0] exp_pc_q[$];
    logic [63:0] model_pc;
    bit          pend;
    logic [63:0] pend_addr;
    int          delivered;

    initial begin
        // ---- rows: rr rv rd ir xv xp h | qv qa iv instr instr_pc ----
        tbl[0]  = mk(1'b1, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 64'h0,      1'b0, 1'b0, A,         1'b0, 32'h0,         A);
        tbl[1]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b1, A,         1'b0, 32'h0,         A);
        tbl[2]  = mk(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, A + 64'h200, 1'b0, 1'b0, A,        1'b0, 32'h0,         A);
        tbl[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0,      1'b0, 1'b0, A,         1'b1, 32'h0000_0013, A);
        tbl[4]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b1, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[5]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b1, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b1, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[7]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b1, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[8]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b1, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[10] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[11] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[12] = mk(1'b0, 1'b1, 32'h00a0_0093, 1'b0, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h4, 1'b0, 32'h0000_0013, A);
        tbl[13] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h4, 1'b1, 32'h00a0_0093, A + 64'h4);
        tbl[14] = mk(1'b0, 1'b1, 32'hffff_ffff, 1'b0, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h4, 1'b1, 32'h00a0_0093, A + 64'h4);
        tbl[15] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, A + 64'h100, 1'b0, 1'b0, A + 64'h4, 1'b1, 32'h00a0_0093, A + 64'h4);
        tbl[16] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 1'b1, A + 64'h100, 1'b0, 32'h00a0_0093, A + 64'h4);
        tbl[17] = mk(1'b0, 1'b1, 32'h0010_0073, 1'b0, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h100, 1'b0, 32'h00a0_0093, A + 64'h4);
        tbl[18] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, A + 64'h300, 1'b1, 1'b0, A + 64'h100, 1'b1, 32'h0010_0073, A + 64'h100);
        tbl[19] = mk(1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 64'h0,      1'b0, 1'b0, A + 64'h100, 1'b0, 32'h0010_0073, A + 64'h100);

        // ---- table run: reset, best case, stalls, redirect, ignored redirect, halt ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            imem_req_ready  = tbl[i].rr;
            imem_resp_valid = tbl[i].rv;
            imem_resp_data  = tbl[i].rd;
            instr_ready     = tbl[i].ir;
            redirect_valid  = tbl[i].xv;
            redirect_pc     = tbl[i].xp;
            halt            = tbl[i].h;
            check($sformatf("vec%0d req_valid", i), 64'(imem_req_valid), 64'(tbl[i].e_qv));
            check($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].e_qa);
            check($sformatf("vec%0d instr_valid", i), 64'(instr_valid), 64'(tbl[i].e_iv));
            check($sformatf("vec%0d instr", i), 64'(instr), 64'(tbl[i].e_id));
            check($sformatf("vec%0d instr_pc", i), instr_pc, tbl[i].e_ip);
            step();
        end

        // ---- halted: no activity for 20 cycles whatever the inputs do ----
        for (int i = 0; i < 20; i++) begin
            imem_req_ready  = 1'($urandom_range(0, 1));
            imem_resp_valid = 1'($urandom_range(0, 1));
            instr_ready     = 1'($urandom_range(0, 1));
            check("halt req_valid", 64'(imem_req_valid), 64'h0);
            check("halt instr_valid", 64'(instr_valid), 64'h0);
            step();
        end

        // ---- reset restarts fetch at RESET_PC ----
        do_reset();
        check("rst instr", 64'(instr), 64'h0);
        check("rst instr_pc", instr_pc, A);
        check("rst idle req_valid", 64'(imem_req_valid), 64'h0);
        step();
        check("rst restart req_valid", 64'(imem_req_valid), 64'h1);
        check("rst restart addr", imem_req_addr, A);

        // ---- reset during WAIT, stale response discarded ----
        imem_req_ready = 1'b1;
        step();
        clear_inputs();
        check("wait req_valid", 64'(imem_req_valid), 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0bad_c0de;
        check("stale idle instr_valid", 64'(instr_valid), 64'h0);
        step();
        check("stale req_valid", 64'(imem_req_valid), 64'h1);
        check("stale req_addr", imem_req_addr, A);
        check("stale instr_valid", 64'(instr_valid), 64'h0);
        step();
        check("stale still req", 64'(imem_req_valid), 64'h1);
        check("stale instr_valid 2", 64'(instr_valid), 64'h0);
        check("stale instr", 64'(instr), 64'h0);

        // ---- misaligned redirect target ----
        fetch_to_hold(32'h0000_0013);
        check("mis hold instr_valid", 64'(instr_valid), 64'h1);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = A + 64'h102;
        step();
        clear_inputs();
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            imem_req_ready = 1'b1;
            check("mis flag", 64'(fetch_misalign), 64'h1);
            check("mis no req", 64'(imem_req_valid), 64'h0);
            check("mis no instr", 64'(instr_valid), 64'h0);
            step();
        end
        do_reset();
        check("mis flag cleared", 64'(fetch_misalign), 64'h0);
`else
        check("mis masked req_valid", 64'(imem_req_valid), 64'h1);
        check("mis masked addr", imem_req_addr, A + 64'h100);
        do_reset();
`endif

        // ---- PC wraps at the top of the address space ----
        step();
        fetch_to_hold(32'h1111_1111);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hffff_ffff_ffff_fffc;
        step();
        clear_inputs();
        check("wrap top addr", imem_req_addr, 64'hffff_ffff_ffff_fffc);
        fetch_to_hold(32'h2222_2222);
        check("wrap top instr_pc", instr_pc, 64'hffff_ffff_ffff_fffc);
        check("wrap top instr", 64'(instr), 64'h2222_2222);
        instr_ready = 1'b1;
        step();
        clear_inputs();
        check("wrap zero addr", imem_req_addr, 64'h0);
        check("wrap zero req_valid", 64'(imem_req_valid), 64'h1);

        // ---- randomized traffic vs. transaction-level model ----
        do_reset();
        exp_q.delete();
        exp_pc_q.delete();
        model_pc  = A;
        pend      = 1'b0;
        pend_addr = 64'h0;
        delivered = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("rnd spurious instr_valid", 64'h1, 64'h0);
                end else begin
                    check("rnd instr", 64'(instr), 64'(exp_q[0]));
                    check("rnd instr_pc", instr_pc, exp_pc_q[0]);
                end
            end
            if (imem_req_valid) begin
                check("rnd req_addr", imem_req_addr, model_pc);
                check("rnd one outstanding", 64'(pend || (exp_q.size() != 0)), 64'h0);
            end

            imem_req_ready  = 1'($urandom_range(0, 1));
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            instr_ready     = 1'($urandom_range(0, 1));
            redirect_valid  = ($urandom_range(0, 3) == 0);
            redirect_pc     = {$urandom, $urandom} & ~64'h3;
            halt            = 1'b0;

            // Fetch stream rules: the next address is redirect target or previous + 4.
            if (instr_valid && instr_ready && exp_q.size() != 0) begin
                model_pc = redirect_valid ? redirect_pc : exp_pc_q[0] + 64'd4;
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
                delivered++;
            end
            if (pend && imem_resp_valid) begin
                exp_q.push_back(imem_resp_data);
                exp_pc_q.push_back(pend_addr);
                pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = model_pc;
            end
            step();
        end
        check("rnd progress", 64'(delivered >= 20), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
